// File: rtl/alt_vipvfr131_common_frame_sequencer.sv
// Frame sequencer for the VIP flow-control input stage: latches frame dimensions,
// requests beats and tags each accepted beat with its x/y position and frame markers.
module alt_vipvfr131_common_frame_sequencer #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic                                        stall_in,
  input  logic                                        end_of_video_in,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic [3:0]                                  interlaced_in,
  input  logic                                        vip_ctrl_valid_in,
  input  logic                                        core_ready,
  output logic                                        read,
  output logic                                        pix_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] pix_data,
  output logic [15:0]                                 pix_x,
  output logic [15:0]                                 pix_y,
  output logic                                        pix_sof,
  output logic                                        pix_eol,
  output logic                                        pix_eof,
  output logic                                        frame_done,
  output logic                                        short_frame,
  output logic                                        long_frame,
  output logic                                        cfg_err
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    ACTIVE   = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          state_q;
  logic [15:0]     pend_w_q, pend_h_q, act_w_q, act_h_q;
  logic [15:0]     x_q, y_q;
  logic            pend_valid_q, act_valid_q, started_q;
  logic            pix_valid_q;
  logic [DW-1:0]   pix_data_q;
  logic [15:0]     pix_x_q, pix_y_q;
  logic            pix_sof_q, pix_eol_q, pix_eof_q;
  logic            frame_done_q, short_frame_q, long_frame_q, cfg_err_q;

  logic [15:0]     h_eff_d, eff_w_s, eff_h_s;
  logic            at_boundary_s, pend_ok_s, apply_s, drop_s, keep_s;
  logic            xfer_s, at_eol_s, at_last_s;
  logic            unused_s;

  assign unused_s = ^interlaced_in[1:0];

  // Effective line count of the incoming set: a field carries half the lines, F0 takes the odd one.
  always_comb begin
    h_eff_d = height_in;
    if (interlaced_in[3]) begin
      if (interlaced_in[2]) begin
        h_eff_d = height_in >> 1;
      end else begin
        h_eff_d = 16'((17'(height_in) + 17'd1) >> 1);
      end
    end else begin
      h_eff_d = height_in;
    end
  end

  // Beat request: follow the core while a frame is active, drain unconditionally when flushing.
  always_comb begin
    read = 1'b0;
    case (state_q)
      ACTIVE:  read = core_ready;
      FLUSH:   read = 1'b1;
      default: read = 1'b0;
    endcase
  end

  // Frame-boundary configuration apply/drop and end-of-frame detection against the effective set.
  always_comb begin
    at_boundary_s = 1'b0;
    if (state_q == WAIT_CFG) begin
      at_boundary_s = 1'b1;
    end else if (state_q == ACTIVE) begin
      at_boundary_s = (x_q == 16'd0) && (y_q == 16'd0) && !started_q;
    end else begin
      at_boundary_s = 1'b0;
    end
    pend_ok_s = pend_valid_q && (pend_w_q != 16'd0) && (pend_h_q != 16'd0);
    apply_s   = at_boundary_s && pend_ok_s;
    drop_s    = at_boundary_s && pend_valid_q && !pend_ok_s;
    // A set applied this cycle already governs a beat accepted in the same cycle.
    if (apply_s) begin
      eff_w_s = pend_w_q;
      eff_h_s = pend_h_q;
      keep_s  = 1'b1;
    end else begin
      eff_w_s = act_w_q;
      eff_h_s = act_h_q;
      keep_s  = act_valid_q && !drop_s;
    end
    xfer_s    = read && !stall_in;
    at_eol_s  = (x_q == eff_w_s - 16'd1);
    at_last_s = at_eol_s && (y_q == eff_h_s - 16'd1);
  end

  // Sequencer state, configuration sets, position counters and registered pixel/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_CFG;
      pend_w_q      <= 16'd0;
      pend_h_q      <= 16'd0;
      pend_valid_q  <= 1'b0;
      act_w_q       <= 16'd0;
      act_h_q       <= 16'd0;
      act_valid_q   <= 1'b0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      started_q     <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= 16'd0;
      pix_y_q       <= 16'd0;
      pix_sof_q     <= 1'b0;
      pix_eol_q     <= 1'b0;
      pix_eof_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      long_frame_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      pix_valid_q   <= 1'b0;
      pix_sof_q     <= 1'b0;
      pix_eol_q     <= 1'b0;
      pix_eof_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      long_frame_q  <= 1'b0;
      cfg_err_q     <= drop_s;

      // A capture in the apply cycle lands in pending after the old pending set was consumed.
      if (vip_ctrl_valid_in) begin
        pend_w_q     <= width_in;
        pend_h_q     <= h_eff_d;
        pend_valid_q <= 1'b1;
      end else if (apply_s || drop_s) begin
        pend_valid_q <= 1'b0;
      end else begin
        pend_valid_q <= pend_valid_q;
      end

      if (apply_s) begin
        act_w_q     <= pend_w_q;
        act_h_q     <= pend_h_q;
        act_valid_q <= 1'b1;
      end else if (drop_s) begin
        act_valid_q <= 1'b0;
      end else begin
        act_valid_q <= act_valid_q;
      end

      case (state_q)
        WAIT_CFG: begin
          if (apply_s) begin
            state_q <= ACTIVE;
          end else begin
            state_q <= WAIT_CFG;
          end
        end
        ACTIVE: begin
          if (xfer_s) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= data_in;
            pix_x_q     <= x_q;
            pix_y_q     <= y_q;
            pix_sof_q   <= (x_q == 16'd0) && (y_q == 16'd0);
            pix_eol_q   <= at_eol_s;
            if (end_of_video_in) begin
              x_q       <= 16'd0;
              y_q       <= 16'd0;
              started_q <= 1'b0;
              if (at_last_s) begin
                pix_eof_q    <= 1'b1;
                frame_done_q <= 1'b1;
              end else begin
                short_frame_q <= 1'b1;
              end
              state_q <= keep_s ? ACTIVE : WAIT_CFG;
            end else if (at_last_s) begin
              pix_eof_q    <= 1'b1;
              long_frame_q <= 1'b1;
              x_q          <= 16'd0;
              y_q          <= 16'd0;
              started_q    <= 1'b1;
              state_q      <= FLUSH;
            end else begin
              started_q <= 1'b1;
              if (at_eol_s) begin
                x_q <= 16'd0;
                y_q <= y_q + 16'd1;
              end else begin
                x_q <= x_q + 16'd1;
              end
            end
          end else begin
            state_q <= ACTIVE;
          end
        end
        FLUSH: begin
          if (xfer_s && end_of_video_in) begin
            x_q       <= 16'd0;
            y_q       <= 16'd0;
            started_q <= 1'b0;
            state_q   <= act_valid_q ? ACTIVE : WAIT_CFG;
          end else begin
            state_q <= FLUSH;
          end
        end
        default: begin
          state_q <= WAIT_CFG;
        end
      endcase
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eol     = pix_eol_q;
  assign pix_eof     = pix_eof_q;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign long_frame  = long_frame_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_alt_vipvfr131_common_frame_sequencer.sv
// Directed bench for the frame sequencer: a frame-level model predicts every cycle's
// outputs from beat indices, and literal expectations pin each scenario.
module tb_alt_vipvfr131_common_frame_sequencer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          stall_in = 1'b1;
  logic          end_of_video_in = 1'b0;
  logic [15:0]   width_in = 16'd0;
  logic [15:0]   height_in = 16'd0;
  logic [3:0]    interlaced_in = 4'd0;
  logic          vip_ctrl_valid_in = 1'b0;
  logic          core_ready = 1'b1;
  logic          read, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [DW-1:0] pix_data;
  logic [15:0]   pix_x, pix_y;
  logic          frame_done, short_frame, long_frame, cfg_err;

  alt_vipvfr131_common_frame_sequencer #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .stall_in         (stall_in),
    .end_of_video_in  (end_of_video_in),
    .width_in         (width_in),
    .height_in        (height_in),
    .interlaced_in    (interlaced_in),
    .vip_ctrl_valid_in(vip_ctrl_valid_in),
    .core_ready       (core_ready),
    .read             (read),
    .pix_valid        (pix_valid),
    .pix_data         (pix_data),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_sof          (pix_sof),
    .pix_eol          (pix_eol),
    .pix_eof          (pix_eof),
    .frame_done       (frame_done),
    .short_frame      (short_frame),
    .long_frame       (long_frame),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  // Frame-level model: mode 0 waiting for config, 1 in a frame, 2 discarding an overlong tail.
  typedef struct {
    int            mode;
    bit            pv;
    longint        pw, ph;
    bit            av;
    longint        aw, ah;
    longint        k;
    bit            v;
    logic [DW-1:0] d;
    int            x, y;
    bit            sof, eol, eof, done, shrt, lng, cerr;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic r, logic ctrl, int w_in, int h_in,
                                  logic [3:0] il, logic cr, logic st, logic eov,
                                  logic [DW-1:0] din);
    model_t n;
    longint w, h;
    bit rd, bnd, last;
    n = c;
    n.v = 0; n.sof = 0; n.eol = 0; n.eof = 0;
    n.done = 0; n.shrt = 0; n.lng = 0; n.cerr = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    w = c.aw;
    h = c.ah;
    bnd = (c.mode == 0) || (c.mode == 1 && c.k == 0);
    if (bnd && c.pv) begin
      n.pv = 0;
      if (c.pw != 0 && c.ph != 0) begin
        n.aw = c.pw; n.ah = c.ph; n.av = 1;
        w = c.pw; h = c.ph;
        if (c.mode == 0) n.mode = 1;
      end else begin
        n.av = 0;
        n.cerr = 1;
      end
    end
    rd = (c.mode == 1) ? bit'(cr) : (c.mode == 2);
    if (rd && !st) begin
      if (c.mode == 1) begin
        last  = (c.k == w * h - 1);
        n.v   = 1;
        n.d   = din;
        n.x   = int'(c.k % w);
        n.y   = int'(c.k / w);
        n.sof = (c.k == 0);
        n.eol = (n.x == w - 1);
        if (eov) begin
          n.k = 0;
          if (last) begin n.eof = 1; n.done = 1; end
          else n.shrt = 1;
          if (!n.av) n.mode = 0;
        end else if (last) begin
          n.eof = 1; n.lng = 1; n.mode = 2; n.k = 0;
        end else begin
          n.k = c.k + 1;
        end
      end else if (eov) begin
        n.k = 0;
        n.mode = n.av ? 1 : 0;
      end
    end
    if (ctrl) begin
      n.pv = 1;
      n.pw = w_in;
      n.ph = il[3] ? (il[2] ? h_in / 2 : (h_in + 1) / 2) : h_in;
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= step(m, rst, vip_ctrl_valid_in, int'(width_in), int'(height_in), interlaced_in,
              core_ready, stall_in, end_of_video_in, data_in);

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int n_pix, n_sof, n_eol, n_eof, n_done, n_short, n_long, n_cerr, n_rd, n_disc, n_rdnocr;
  int last_eof_y;

  // Per-cycle comparison against the model plus scenario observers.
  always @(negedge clk) begin
    check("read", read, (m.mode == 1) ? longint'(core_ready) : longint'(m.mode == 2));
    check("pix_valid", pix_valid, m.v);
    if (m.v) begin
      check("pix_data", pix_data, m.d);
      check("pix_x", pix_x, m.x);
      check("pix_y", pix_y, m.y);
      check("pix_sof", pix_sof, m.sof);
      check("pix_eol", pix_eol, m.eol);
      check("pix_eof", pix_eof, m.eof);
    end
    check("frame_done", frame_done, m.done);
    check("short_frame", short_frame, m.shrt);
    check("long_frame", long_frame, m.lng);
    check("cfg_err", cfg_err, m.cerr);
    if (pix_valid) begin
      n_pix++;
      if (pix_sof) n_sof++;
      if (pix_eol) n_eol++;
      if (pix_eof) begin n_eof++; last_eof_y = int'(pix_y); end
    end
    if (frame_done) n_done++;
    if (short_frame) n_short++;
    if (long_frame) n_long++;
    if (cfg_err) n_cerr++;
    if (read) n_rd++;
    if (read && !stall_in && !core_ready) n_disc++;
    if (read && !core_ready) n_rdnocr++;
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          eov;
  } beat_t;

  beat_t src_q[$];
  int    seq = 256;
  int    cyc = 0;
  int    n_took = 0;
  int    cr_mode = 0;
  bit    stall_mode = 0;
  bit    took;

  task automatic clear_obs();
    n_pix = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0; n_short = 0; n_long = 0;
    n_cerr = 0; n_rd = 0; n_disc = 0; n_rdnocr = 0; last_eof_y = -1; n_took = 0;
  endtask

  task automatic drive_src();
    if (src_q.size() > 0 && !(stall_mode && (cyc % 3 == 0))) begin
      stall_in        = 1'b0;
      data_in         = src_q[0].d;
      end_of_video_in = src_q[0].eov;
    end else begin
      stall_in        = 1'b1;
      data_in         = '0;
      end_of_video_in = 1'b0;
    end
  endtask

  task automatic push_frame(input int n, input int eov_at);
    for (int i = 1; i <= n; i++) begin
      src_q.push_back({DW'(seq), (i == eov_at)});
      seq++;
    end
    drive_src();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      took = read && !stall_in && !rst;
      @(posedge clk);
      #1;
      if (took) begin
        void'(src_q.pop_front());
        n_took++;
      end
      cyc++;
      if (cr_mode == 0) core_ready = 1'b1;
      else if (cr_mode == 1) core_ready = ((cyc % 2) == 0);
      else core_ready = (n_took < 8);
      drive_src();
    end
  endtask

  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    width_in          = w;
    height_in         = h;
    interlaced_in     = il;
    vip_ctrl_valid_in = 1'b1;
    run(1);
    vip_ctrl_valid_in = 1'b0;
  endtask

  initial begin
    int g;
    clear_obs();
    run(3);
    rst = 1'b0;

    // Zero width: error pulse, never reads.
    clear_obs();
    send_ctrl(16'd0, 16'd2, 4'b0000);
    run(5);
    check("zero_cfg_err_count", n_cerr, 1);
    check("zero_cfg_read_count", n_rd, 0);

    // Nominal 4x2 frame.
    clear_obs();
    send_ctrl(16'd4, 16'd2, 4'b0000);
    push_frame(8, 8);
    run(20);
    check("nom_pixels", n_pix, 8);
    check("nom_sof", n_sof, 1);
    check("nom_eol", n_eol, 2);
    check("nom_eof", n_eof, 1);
    check("nom_eof_y", last_eof_y, 1);
    check("nom_done", n_done, 1);

    // Short frame, then a full frame restarting at the origin.
    clear_obs();
    push_frame(5, 5);
    run(15);
    check("short_pixels", n_pix, 5);
    check("short_pulse", n_short, 1);
    check("short_eof", n_eof, 0);
    clear_obs();
    push_frame(8, 8);
    run(20);
    check("after_short_sof", n_sof, 1);
    check("after_short_done", n_done, 1);

    // Long frame: 8 pixels, 3 beats drained with core_ready low.
    clear_obs();
    cr_mode = 2;
    push_frame(11, 11);
    run(30);
    check("long_pixels", n_pix, 8);
    check("long_eof", n_eof, 1);
    check("long_pulse", n_long, 1);
    check("long_discarded", n_disc, 3);
    clear_obs();
    cr_mode = 0;
    push_frame(8, 8);
    run(20);
    check("after_long_done", n_done, 1);

    // Interlaced F0 (H=5 -> 3 lines) with a mid-frame F1 update, then F1 (2 lines).
    clear_obs();
    send_ctrl(16'd4, 16'd5, 4'b1000);
    push_frame(12, 12);
    run(6);
    send_ctrl(16'd4, 16'd5, 4'b1100);
    run(20);
    check("f0_eof_y", last_eof_y, 2);
    check("f0_done", n_done, 1);
    clear_obs();
    push_frame(8, 8);
    run(20);
    check("f1_eof_y", last_eof_y, 1);
    check("f1_done", n_done, 1);
    check("f1_pixels", n_pix, 8);

    // Backpressure on both sides: no lost pixel, no read while core_ready is low.
    clear_obs();
    cr_mode = 1;
    stall_mode = 1;
    push_frame(8, 8);
    run(40);
    check("bp_pixels", n_pix, 8);
    check("bp_done", n_done, 1);
    check("bp_read_without_ready", n_rdnocr, 0);
    cr_mode = 0;
    stall_mode = 0;
    drive_src();

    // Reset in the middle of a frame.
    clear_obs();
    push_frame(8, 8);
    g = 0;
    while (n_pix < 3 && g < 20) begin
      run(1);
      g++;
    end
    check("rst_pix3_seen", longint'(n_pix >= 3), 1);
    rst = 1'b1;
    src_q.delete();
    drive_src();
    run(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_read", read, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_flags", {pix_sof, pix_eol, pix_eof, frame_done, short_frame, long_frame, cfg_err}, 0);
    clear_obs();
    run(10);
    check("rst_wait_read", n_rd, 0);
    check("rst_wait_pulses", n_done + n_short + n_long + n_cerr, 0);
    clear_obs();
    send_ctrl(16'd4, 16'd2, 4'b0000);
    push_frame(8, 8);
    run(20);
    check("post_rst_done", n_done, 1);
    check("post_rst_pixels", n_pix, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
